// File: rtl/pixel_frame_controller_if.sv
// Bundle of the camera-control, pixel-array and readout signals around the
// global-shutter frame controller. The controller takes the master view.
interface pixel_frame_controller_if #(
   parameter int COUNT_WIDTH  = 8,
   parameter int NUM_ROWS     = 2,
   parameter int EXPOSE_WIDTH = 16
);
   localparam int ROW_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   // camera control side
   logic                    start;
   logic                    abort;
   logic [EXPOSE_WIDTH-1:0] expose_time;
   logic                    busy;
   logic                    frame_done;

   // pixel array side
   logic                    power_enable;
   logic                    reset;
   logic                    erase;
   logic                    expose;
   logic                    counter_reset;
   logic                    counter_clock;
   logic                    write_enable;
   logic [COUNT_WIDTH-1:0]  ramp_code;

   // readout side
   logic [ROW_WIDTH-1:0]    read_row;
   logic                    read_valid;
   logic                    read_ready;

   modport master (
      input  start, abort, expose_time, read_ready,
      output busy, frame_done, power_enable, reset, erase, expose,
             counter_reset, counter_clock, write_enable, ramp_code,
             read_row, read_valid
   );

   modport slave (
      output start, abort, expose_time, read_ready,
      input  busy, frame_done, power_enable, reset, erase, expose,
             counter_reset, counter_clock, write_enable, ramp_code,
             read_row, read_valid
   );

   modport monitor (
      input  busy, frame_done, power_enable, reset, erase, expose,
             counter_reset, counter_clock, write_enable, ramp_code,
             read_valid
   );
endinterface

// File: rtl/pixel_frame_controller.sv
// Global-shutter frame sequencer: erase, exposure, single-slope conversion
// and row readout. Every output is a flop loaded from the look-ahead
// (next-state) decode, so outputs line up with the state they belong to and
// no input reaches an output combinationally.
module pixel_frame_controller #(
   parameter int COUNT_WIDTH  = 8,
   parameter int NUM_ROWS     = 2,
   parameter int ERASE_CYCLES = 4,
   parameter int EXPOSE_WIDTH = 16
) (
   input logic                       clk,
   input logic                       rst_n,
   pixel_frame_controller_if.master  bus
);

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int ROW_WIDTH   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   // conversion phase counter: low bit is the clock phase, upper bits the code
   localparam int CONV_WIDTH  = COUNT_WIDTH + 1;
   localparam int ERASE_WIDTH = $clog2(ERASE_CYCLES + 1);
   localparam int CNT_WIDTH   = max_int(max_int(EXPOSE_WIDTH, CONV_WIDTH), ERASE_WIDTH);

   localparam logic [CNT_WIDTH-1:0] ERASE_LAST = CNT_WIDTH'(ERASE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CONV_LAST  = CNT_WIDTH'({CONV_WIDTH{1'b1}});
   localparam logic [ROW_WIDTH-1:0] ROW_LAST   = ROW_WIDTH'(NUM_ROWS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ERASE     = 3'd1,
      ST_EXPOSE    = 3'd2,
      ST_CONV_INIT = 3'd3,
      ST_CONVERT   = 3'd4,
      ST_READ      = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   state_t                  state_r;
   state_t                  next_state_s;
   logic [CNT_WIDTH-1:0]    cnt_r;
   logic [CNT_WIDTH-1:0]    cnt_next_s;
   logic [EXPOSE_WIDTH-1:0] expose_len_r;
   logic [ROW_WIDTH-1:0]    row_r;
   logic [ROW_WIDTH-1:0]    row_next_s;
   logic                    expose_last_s;
   logic                    row_accept_s;

   // look-ahead output values and their registers
   logic                    busy_s,          busy_r;
   logic                    frame_done_s,    frame_done_r;
   logic                    power_enable_s,  power_enable_r;
   logic                    reset_s,         reset_r;
   logic                    erase_s,         erase_r;
   logic                    expose_s,        expose_r;
   logic                    counter_reset_s, counter_reset_r;
   logic                    counter_clock_s, counter_clock_r;
   logic                    write_enable_s,  write_enable_r;
   logic [COUNT_WIDTH-1:0]  ramp_code_s,     ramp_code_r;
   logic [ROW_WIDTH-1:0]    read_row_s,      read_row_r;
   logic                    read_valid_s,    read_valid_r;

   assign expose_last_s = (cnt_r == (CNT_WIDTH'(expose_len_r) - CNT_WIDTH'(1)));
   assign row_accept_s  = read_valid_r && bus.read_ready;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // next-state decode; abort outranks every other transition
   always_comb begin
      next_state_s = state_r;
      if ((state_r != ST_IDLE) && bus.abort) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) next_state_s = ST_ERASE;
               else           next_state_s = ST_IDLE;
            end
            ST_ERASE: begin
               if (cnt_r == ERASE_LAST) next_state_s = ST_EXPOSE;
               else                     next_state_s = ST_ERASE;
            end
            ST_EXPOSE: begin
               if (expose_last_s) next_state_s = ST_CONV_INIT;
               else               next_state_s = ST_EXPOSE;
            end
            ST_CONV_INIT: next_state_s = ST_CONVERT;
            ST_CONVERT: begin
               if (cnt_r == CONV_LAST) next_state_s = ST_READ;
               else                    next_state_s = ST_CONVERT;
            end
            ST_READ: begin
               if (row_accept_s && (row_r == ROW_LAST)) next_state_s = ST_DONE;
               else                                     next_state_s = ST_READ;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
         endcase
      end
   end

   // next values of the in-state cycle counter and the readout row
   always_comb begin
      cnt_next_s = cnt_r;
      row_next_s = row_r;
      if (next_state_s != state_r) begin
         cnt_next_s = '0;
      end else if ((state_r == ST_ERASE) || (state_r == ST_EXPOSE) ||
                   (state_r == ST_CONVERT)) begin
         cnt_next_s = cnt_r + CNT_WIDTH'(1);
      end else begin
         cnt_next_s = cnt_r;
      end
      if (next_state_s != ST_READ) begin
         row_next_s = '0;
      end else if ((state_r == ST_READ) && row_accept_s) begin
         row_next_s = row_r + ROW_WIDTH'(1);
      end else begin
         row_next_s = row_r;
      end
   end

   // cycle counter, readout row and exposure-length latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r        <= '0;
         row_r        <= '0;
         expose_len_r <= '0;
      end else begin
         cnt_r <= cnt_next_s;
         row_r <= row_next_s;
         if ((state_r == ST_IDLE) && bus.start) begin
            // a zero exposure request still exposes for one cycle
            if (bus.expose_time == '0) expose_len_r <= EXPOSE_WIDTH'(1);
            else                       expose_len_r <= bus.expose_time;
         end else begin
            expose_len_r <= expose_len_r;
         end
      end
   end

   // output decode from the state being entered
   always_comb begin
      busy_s          = 1'b0;
      frame_done_s    = 1'b0;
      power_enable_s  = 1'b0;
      reset_s         = 1'b0;
      erase_s         = 1'b0;
      expose_s        = 1'b0;
      counter_reset_s = 1'b0;
      counter_clock_s = 1'b0;
      write_enable_s  = 1'b0;
      ramp_code_s     = '0;
      read_row_s      = '0;
      read_valid_s    = 1'b0;
      case (next_state_s)
         ST_ERASE: begin
            busy_s         = 1'b1;
            power_enable_s = 1'b1;
            reset_s        = 1'b1;
            erase_s        = 1'b1;
         end
         ST_EXPOSE: begin
            busy_s         = 1'b1;
            power_enable_s = 1'b1;
            expose_s       = 1'b1;
         end
         ST_CONV_INIT: begin
            busy_s          = 1'b1;
            power_enable_s  = 1'b1;
            counter_reset_s = 1'b1;
         end
         ST_CONVERT: begin
            // even phase = clock high; code advances after each low phase
            busy_s          = 1'b1;
            power_enable_s  = 1'b1;
            write_enable_s  = 1'b1;
            counter_clock_s = ~cnt_next_s[0];
            ramp_code_s     = cnt_next_s[CONV_WIDTH-1:1];
         end
         ST_READ: begin
            busy_s       = 1'b1;
            read_valid_s = 1'b1;
            read_row_s   = row_next_s;
         end
         ST_DONE: begin
            busy_s       = 1'b1;
            frame_done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r          <= 1'b0;
         frame_done_r    <= 1'b0;
         power_enable_r  <= 1'b0;
         reset_r         <= 1'b0;
         erase_r         <= 1'b0;
         expose_r        <= 1'b0;
         counter_reset_r <= 1'b0;
         counter_clock_r <= 1'b0;
         write_enable_r  <= 1'b0;
         ramp_code_r     <= '0;
         read_row_r      <= '0;
         read_valid_r    <= 1'b0;
      end else begin
         busy_r          <= busy_s;
         frame_done_r    <= frame_done_s;
         power_enable_r  <= power_enable_s;
         reset_r         <= reset_s;
         erase_r         <= erase_s;
         expose_r        <= expose_s;
         counter_reset_r <= counter_reset_s;
         counter_clock_r <= counter_clock_s;
         write_enable_r  <= write_enable_s;
         ramp_code_r     <= ramp_code_s;
         read_row_r      <= read_row_s;
         read_valid_r    <= read_valid_s;
      end
   end

   assign bus.busy          = busy_r;
   assign bus.frame_done    = frame_done_r;
   assign bus.power_enable  = power_enable_r;
   assign bus.reset         = reset_r;
   assign bus.erase         = erase_r;
   assign bus.expose        = expose_r;
   assign bus.counter_reset = counter_reset_r;
   assign bus.counter_clock = counter_clock_r;
   assign bus.write_enable  = write_enable_r;
   assign bus.ramp_code     = ramp_code_r;
   assign bus.read_row      = read_row_r;
   assign bus.read_valid    = read_valid_r;

endmodule

// Pixel-control invariants watched from the output pins.
module pixel_frame_controller_checker (
   input logic                       clk,
   input logic                       rst_n,
   pixel_frame_controller_if.monitor bus
);

   // erase and exposure are mutually exclusive
   a_erase_expose: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.erase && bus.expose));

   // write enable only with the conversion-state output pattern
   a_write_in_convert: assert property (@(posedge clk) disable iff (!rst_n)
      bus.write_enable |-> (bus.power_enable && bus.busy && !bus.counter_reset &&
                            !bus.read_valid && !bus.erase && !bus.expose && !bus.reset));

   // counter clear never meets a high counter clock
   a_reset_vs_clock: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.counter_reset && bus.counter_clock));

   // ramp is monotonic through a conversion and never wraps
   a_ramp_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.write_enable && $past(bus.write_enable)) |-> (bus.ramp_code >= $past(bus.ramp_code)));

   // idle means every pixel control is quiet
   a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
      !bus.busy |-> !(bus.power_enable || bus.reset || bus.erase || bus.expose ||
                      bus.counter_reset || bus.counter_clock || bus.write_enable ||
                      bus.read_valid || bus.frame_done));

endmodule
